// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared encodings for the SNN input-encoder slice
//
// Purpose: FSM state encodings, encoder mode constants and the LFSR tap mask
//   shared by spike_encoder_rate and spike_lfsr16.
// Ports: none (package).
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } enc_state_t;

  localparam logic ENC_MODE_RATE    = 1'b0;
  localparam logic ENC_MODE_POISSON = 1'b1;

  // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/spike_lfsr16.sv
// rtl/spike_lfsr16.sv - 16-bit Fibonacci LFSR, shift-left, enable-gated
//
// Purpose: pseudo-random source for Poisson spike coding.
// Ports:
//   i_clk    in   1   clock
//   i_rst    in   1   synchronous active-high reset, loads the seed
//   i_en     in   1   advance one position
//   o_state  out  16  current register contents
module spike_lfsr16
  import snn_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic [15:0] o_state
);

  // An all-zero state would lock the register, so a zero seed is replaced.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic feedback;

  assign feedback = ^(o_state & LFSR_TAPS);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_state <= SEED_EFF;
    end else if (i_en) begin
      o_state <= {o_state[14:0], feedback};
    end
  end

endmodule

// File: rtl/spike_encoder_rate.sv
// rtl/spike_encoder_rate.sv - intensity to spike-train encoder (rate / Poisson)
//
// Purpose: accepts one intensity sample and presents NUM_STEPS timesteps of
//   spike current for a downstream neuron, one step per i_step_en strobe.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid / o_ready   sample handshake (accepted when both high)
//   i_intensity, i_mode sample intensity and coding mode, latched on accept
//   i_step_en           timestep strobe
//   o_spike             SPIKE_AMPLITUDE on a spike step, else 0
//   o_spike_valid       spike presented this cycle
//   o_step_idx          index of the step presented
//   o_busy, o_done      running / one-cycle sample-finished pulse
module spike_encoder_rate
  import snn_pkg::*;
#(
  parameter int          DATA_LENGTH     = 8,
  parameter int          NUM_STEPS       = 16,
  parameter int          SPIKE_AMPLITUDE = 200,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  localparam int         STEP_W          = $clog2(NUM_STEPS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [DATA_LENGTH-1:0] i_intensity,
  input  logic                   i_mode,
  input  logic                   i_step_en,
  output logic [DATA_LENGTH-1:0] o_spike,
  output logic                   o_spike_valid,
  output logic [STEP_W-1:0]      o_step_idx,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam logic [STEP_W-1:0]      LAST_STEP = STEP_W'(NUM_STEPS - 1);
  localparam logic [DATA_LENGTH-1:0] AMP       = DATA_LENGTH'(SPIKE_AMPLITUDE);

  enc_state_t             state_q, state_d;
  logic [DATA_LENGTH-1:0] intensity_q;
  logic [DATA_LENGTH-1:0] acc_q;
  logic                   mode_q;
  logic [STEP_W-1:0]      cnt_q;
  // Set once the final step has been taken; the RUN state then lingers one
  // cycle so the last step's output is presented before the DONE pulse.
  logic                   fin_q;
  logic [15:0]            lfsr_state;
  logic [DATA_LENGTH:0]   sum;
  logic                   accept;
  logic                   step;
  logic                   spike;
  logic                   lfsr_en;
  logic                   lfsr_unused;

  assign accept  = (state_q == ST_IDLE) && i_valid;
  assign step    = (state_q == ST_RUN) && !fin_q && i_step_en;
  assign sum     = {1'b0, acc_q} + {1'b0, intensity_q};
  assign lfsr_en = step && (mode_q == ENC_MODE_POISSON);
  // Only the low DATA_LENGTH bits feed the compare.
  assign lfsr_unused = &{1'b0, lfsr_state};

  spike_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (lfsr_en),
    .o_state (lfsr_state)
  );

  always_comb begin
    spike = 1'b0;
    if (mode_q == ENC_MODE_POISSON) begin
      spike = lfsr_state[DATA_LENGTH-1:0] < intensity_q;
    end else begin
      // Carry out of the accumulator yields floor(N*I/2^DATA_LENGTH) spikes.
      spike = sum[DATA_LENGTH];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (fin_q) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Status outputs are registered copies of the next state so they line up
  // with state_q on every cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ready <= 1'b1;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_ready <= (state_d == ST_IDLE);
      o_busy  <= (state_d == ST_RUN);
      o_done  <= (state_d == ST_DONE);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_spike       <= '0;
      o_spike_valid <= 1'b0;
      o_step_idx    <= '0;
    end else begin
      o_spike       <= (step && spike) ? AMP : '0;
      o_spike_valid <= step && spike;
      if (step) begin
        o_step_idx <= cnt_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      intensity_q <= '0;
      mode_q      <= ENC_MODE_RATE;
      acc_q       <= '0;
      cnt_q       <= '0;
      fin_q       <= 1'b0;
    end else if (accept) begin
      intensity_q <= i_intensity;
      mode_q      <= i_mode;
      acc_q       <= '0;
      cnt_q       <= '0;
      fin_q       <= 1'b0;
    end else if (step) begin
      if (mode_q == ENC_MODE_RATE) begin
        acc_q <= sum[DATA_LENGTH-1:0];
      end
      if (cnt_q == LAST_STEP) begin
        fin_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spike_encoder_rate.sv
// tb/tb_spike_encoder_rate.sv - self-checking bench for spike_encoder_rate
module tb_spike_encoder_rate;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [7:0]  AMP  = 8'd200;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       ready;
  logic [7:0] intensity;
  logic       mode;
  logic       step_en;
  logic [7:0] spike;
  logic       spike_valid;
  logic [3:0] step_idx;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  logic [15:0] lfsr_m = SEED;

  always #5 clk = ~clk;

  spike_encoder_rate dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_valid       (valid),
    .o_ready       (ready),
    .i_intensity   (intensity),
    .i_mode        (mode),
    .i_step_en     (step_en),
    .o_spike       (spike),
    .o_spike_valid (spike_valid),
    .o_step_idx    (step_idx),
    .o_busy        (busy),
    .o_done        (done)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // One full sample: handshake, NUM_STEPS strobes every `stride` cycles,
  // per-step comparison against the model, then the DONE pulse.
  task automatic run_sample(input int inten, input bit md, input int stride,
                            input bit hold, output int nspk, output int waitc);
    bit exp_s[16];
    int step_no;
    int cyc;
    bit en;
    bit exp_v;
    for (int k = 0; k < 16; k++) begin
      if (md == 1'b0) begin
        exp_s[k] = (((k + 1) * inten) >> 8) != ((k * inten) >> 8);
      end else begin
        exp_s[k] = (int'(lfsr_m[7:0]) < inten);
        lfsr_m = lfsr_next(lfsr_m);
      end
    end
    nspk  = 0;
    waitc = 0;
    step_en = 1'b0;
    do begin
      @(negedge clk);
      waitc++;
      checks++;
      if (done !== 1'b0 && waitc > 1) begin
        errors++;
        $display("FAIL done_len: o_done=%0b at wait cycle %0d, required 0", done, waitc);
      end
    end while (!ready && waitc < 100);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: o_ready=%0b, required 1", ready);
      return;
    end
    intensity = 8'(inten);
    mode      = md;
    valid     = 1'b1;
    @(negedge clk);
    valid = hold;
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL accept: busy=%0b ready=%0b, required 1 0", busy, ready);
    end
    step_no = 0;
    cyc     = 0;
    while (step_no < 16 && cyc < 16 * stride + 16) begin
      en = (cyc % stride) == 0;
      step_en = en;
      if (hold) begin
        intensity = 8'($urandom);
        mode      = 1'($urandom);
      end
      @(negedge clk);
      exp_v = en && exp_s[step_no];
      checks++;
      if (spike_valid !== exp_v || spike !== (exp_v ? AMP : 8'd0)) begin
        errors++;
        $display("FAIL step: cyc=%0d step=%0d valid=%0b spike=%0d, required %0b %0d",
                 cyc, step_no, spike_valid, spike, exp_v, exp_v ? AMP : 8'd0);
      end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL run_status: busy=%0b done=%0b, required 1 0", busy, done);
      end
      if (spike_valid === 1'b1) nspk++;
      if (en) begin
        checks++;
        if (step_idx !== 4'(step_no)) begin
          errors++;
          $display("FAIL step_idx: got %0d, required %0d", step_idx, step_no);
        end
        step_no++;
      end
      cyc++;
    end
    // Extra strobe after the last step must be ignored.
    step_en = 1'b1;
    @(negedge clk);
    step_en = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || ready !== 1'b0 || spike_valid !== 1'b0) begin
      errors++;
      $display("FAIL done: done=%0b busy=%0b ready=%0b sv=%0b, required 1 0 0 0",
               done, busy, ready, spike_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid = 1'b1;
    intensity = 8'd255;
    mode = 1'b0;
    step_en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || spike !== 8'd0 ||
        spike_valid !== 1'b0 || step_idx !== 4'd0) begin
      errors++;
      $display("FAIL reset: rdy=%0b busy=%0b done=%0b spk=%0d sv=%0b idx=%0d, required 1 0 0 0 0 0",
               ready, busy, done, spike, spike_valid, step_idx);
    end
    rst = 1'b0;
    valid = 1'b0;
    step_en = 1'b0;
    lfsr_m = SEED;
  endtask

  task automatic test_rate_fixed();
    int ints[3] = '{128, 255, 0};
    int want[3] = '{8, 15, 0};
    int n, w;
    foreach (ints[i]) begin
      run_sample(ints[i], 1'b0, 1, 1'b0, n, w);
      checks++;
      if (n !== want[i]) begin
        errors++;
        $display("FAIL rate_count I=%0d: got %0d spikes, required %0d", ints[i], n, want[i]);
      end
    end
  endtask

  task automatic test_rate_random();
    int n, w, iv;
    for (int i = 0; i < 6; i++) begin
      iv = $urandom_range(0, 255);
      run_sample(iv, 1'b0, 1, 1'b0, n, w);
      checks++;
      if (n !== ((16 * iv) >> 8)) begin
        errors++;
        $display("FAIL rate_rand I=%0d: got %0d spikes, required %0d", iv, n, (16 * iv) >> 8);
      end
    end
  endtask

  task automatic test_poisson();
    int n, w, total, exp_total;
    logic [15:0] s;
    run_sample(0, 1'b1, 1, 1'b0, n, w);
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL poisson_zero: got %0d spikes, required 0", n);
    end
    s = lfsr_m;
    exp_total = 0;
    for (int i = 0; i < 64 * 16; i++) begin
      if (s[7:0] < 8'd255) exp_total++;
      s = lfsr_next(s);
    end
    total = 0;
    for (int i = 0; i < 64; i++) begin
      run_sample(255, 1'b1, 1, 1'b0, n, w);
      total += n;
    end
    checks++;
    if (total !== exp_total) begin
      errors++;
      $display("FAIL poisson_255: got %0d spikes, required %0d", total, exp_total);
    end
    for (int i = 0; i < 4; i++) run_sample($urandom_range(1, 254), 1'b1, 1, 1'b0, n, w);
  endtask

  task automatic test_stride();
    int n, w;
    run_sample($urandom_range(0, 255), 1'b0, 3, 1'b0, n, w);
    run_sample($urandom_range(0, 255), 1'b1, 3, 1'b0, n, w);
  endtask

  task automatic test_back_to_back();
    int n, w;
    run_sample($urandom_range(0, 255), 1'b0, 1, 1'b1, n, w);
    run_sample($urandom_range(0, 255), 1'b1, 2, 1'b1, n, w);
    checks++;
    if (w !== 1) begin
      errors++;
      $display("FAIL back_to_back: accepted after %0d wait cycles, required 1", w);
    end
    valid = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int n, w;
    @(negedge clk);
    intensity = 8'd200;
    mode = 1'b1;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    step_en = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    valid = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || spike !== 8'd0 ||
        spike_valid !== 1'b0 || step_idx !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset: rdy=%0b busy=%0b done=%0b spk=%0d sv=%0b idx=%0d, required 1 0 0 0 0 0",
               ready, busy, done, spike, spike_valid, step_idx);
    end
    rst = 1'b0;
    valid = 1'b0;
    step_en = 1'b0;
    lfsr_m = SEED;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: busy=%0b ready=%0b done=%0b, required 0 1 0", busy, ready, done);
    end
    run_sample($urandom_range(1, 254), 1'b1, 1, 1'b0, n, w);
  endtask

  initial begin
    rst = 1'b1;
    valid = 1'b0;
    intensity = '0;
    mode = 1'b0;
    step_en = 1'b0;
    test_reset();
    test_rate_fixed();
    test_rate_random();
    test_poisson();
    test_stride();
    test_back_to_back();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
